// File: rtl/reg_scoreboard.sv
// Register-hazard scoreboard: per-register pending bit plus result-latency countdown,
// producing issue stall and per-source bypass select. Optional SCOREBOARD_STATS_EN adds a stall-cycle counter.
module reg_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int REG_AW   = 5,
    parameter int NUM_RS   = 2,
    parameter int LAT_W    = 3
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_issue_valid,
    input  logic                         i_issue_wb,
    input  logic [REG_AW-1:0]            i_issue_rd,
    input  logic [LAT_W-1:0]             i_issue_lat,
    input  logic [NUM_RS*REG_AW-1:0]     i_rs_no,
    input  logic [NUM_RS-1:0]            i_rs_used,
    output logic                         o_stall,
    output logic [NUM_RS-1:0]            o_rs_fwd,
    input  logic                         i_wb_valid,
    input  logic [REG_AW-1:0]            i_wb_rd,
    input  logic                         i_kill_valid,
    input  logic [REG_AW-1:0]            i_kill_rd,
    output logic [$clog2(NUM_REGS+1)-1:0] o_pending_cnt
`ifdef SCOREBOARD_STATS_EN
    ,
    output logic [31:0]                  o_stall_cycles
`endif
);

    localparam int PCW = $clog2(NUM_REGS+1);

    logic [NUM_REGS-1:0] pend;
    logic [NUM_REGS-1:0] pend_next;
    logic [LAT_W-1:0]    cnt      [NUM_REGS];
    logic [LAT_W-1:0]    cnt_next [NUM_REGS];

    logic [NUM_RS-1:0]   rs_pend;
    logic [NUM_RS-1:0]   rs_busy;
    logic [NUM_RS-1:0]   raw;
    logic                rd_pend;
    logic [LAT_W-1:0]    rd_cnt;
    logic                waw;
    logic                accept;
    logic [PCW-1:0]      pend_sum;

    // Source lookups read registered state only, so an rd=rs issue sees the old producer.
    always_comb begin
        rs_pend  = '0;
        rs_busy  = '0;
        raw      = '0;
        o_rs_fwd = '0;
        for (int k = 0; k < NUM_RS; k++) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (i_rs_no[k*REG_AW +: REG_AW] == REG_AW'(r)) begin
                    rs_pend[k] = pend[r];
                    rs_busy[k] = (cnt[r] != '0);
                end
            end
            raw[k]      = i_rs_used[k] & rs_pend[k] & rs_busy[k];
            o_rs_fwd[k] = i_rs_used[k] & rs_pend[k] & ~rs_busy[k];
        end
    end

    always_comb begin
        rd_pend = 1'b0;
        rd_cnt  = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (i_issue_rd == REG_AW'(r)) begin
                rd_pend = pend[r];
                rd_cnt  = cnt[r];
            end
        end
    end

    // A later producer may only overtake an older one if its result lands no earlier.
    assign waw     = i_issue_wb & (i_issue_rd != '0) & rd_pend & (rd_cnt > i_issue_lat);
    assign o_stall = i_issue_valid & ((|raw) | waw);
    assign accept  = i_issue_valid & ~o_stall;

    always_comb begin
        pend_next = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_next[r] = '0;
        end
        // Entry 0 keeps its all-zero defaults; x0 never becomes pending.
        for (int r = 1; r < NUM_REGS; r++) begin
            if (accept && i_issue_wb && (i_issue_rd == REG_AW'(r))) begin
                pend_next[r] = 1'b1;
                cnt_next[r]  = i_issue_lat;
            end else if ((i_kill_valid && (i_kill_rd == REG_AW'(r))) ||
                         (i_wb_valid && (i_wb_rd == REG_AW'(r)))) begin
                pend_next[r] = 1'b0;
                cnt_next[r]  = '0;
            end else if (pend[r]) begin
                pend_next[r] = 1'b1;
                cnt_next[r]  = (cnt[r] != '0) ? cnt[r] - LAT_W'(1) : '0;
            end
        end
        pend_sum = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            pend_sum = pend_sum + PCW'(pend_next[r]);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pend          <= '0;
            o_pending_cnt <= '0;
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            pend          <= pend_next;
            o_pending_cnt <= pend_sum;
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt[r] <= cnt_next[r];
            end
        end
    end

`ifdef SCOREBOARD_STATS_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_stall_cycles <= '0;
        end else if (o_stall && (o_stall_cycles != 32'hFFFF_FFFF)) begin
            o_stall_cycles <= o_stall_cycles + 32'd1;
        end
    end
`else
    // Stall statistics are not built in this configuration.
`endif

endmodule
